// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared state encoding and frame constants for the boot loader
package boot_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int WORD_WIDTH     = 32;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CSUM,
    ST_HOLD,
    ST_RUN,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/boot_loader_if.sv
// rtl/boot_loader_if.sv - byte receive stream, imem write port and core control
interface boot_loader_if #(parameter int ADDR_WIDTH = 8);
  import boot_loader_pkg::*;

  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [WORD_WIDTH-1:0] imem_wdata;
  logic                  core_reset;
  logic                  load_done;
  logic                  error;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, core_reset, load_done, error
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, core_reset, load_done, error
  );

endinterface

// File: rtl/boot_loader_word_packer.sv
// rtl/boot_loader_word_packer.sv - little-endian byte-to-word assembler
// word_valid/word_data are combinational and qualify the byte completing a word.
module boot_loader_word_packer
  import boot_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  word_valid,
  output logic [WORD_WIDTH-1:0] word_data
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam int LOW_W = WORD_WIDTH - 8;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LOW_W-1:0] low_q, low_d;

  always_comb begin
    idx_d      = idx_q;
    low_d      = low_q;
    word_valid = byte_valid && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    word_data  = {byte_data, low_q};
    if (byte_valid) begin
      // Index wraps to zero on the last byte, ready for the next word.
      idx_d = idx_q + IDX_W'(1);
      low_d = {byte_data, low_q[LOW_W-1:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      low_q <= '0;
    end else begin
      idx_q <= idx_d;
      low_q <= low_d;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - framed byte-stream image loader holding the core in reset
// Define BOOT_LOADER_CSUM_EN to expect and check a trailing XOR checksum byte.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RESET_HOLD = 8
) (
  input logic         clk,
  input logic         reset,
  boot_loader_if.slave bus
);

  localparam int COUNT_WIDTH = HDR_BYTES * 8;
  localparam int HOLD_W      = $clog2(RESET_HOLD + 1);
  localparam logic [COUNT_WIDTH:0] CAPACITY = {{COUNT_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;
`ifdef BOOT_LOADER_CSUM_EN
  localparam state_t POST_DATA = ST_CSUM;
`else
  localparam state_t POST_DATA = ST_HOLD;
`endif

  state_t                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic [COUNT_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
  logic [WORD_WIDTH-1:0]   imem_wdata_q, imem_wdata_d;
`ifdef BOOT_LOADER_CSUM_EN
  logic [7:0]              csum_q, csum_d;
`endif

  logic                    rx_ready;
  logic                    fire;
  logic                    byte_valid;
  logic                    word_valid;
  logic [WORD_WIDTH-1:0]   word_data;
  logic [COUNT_WIDTH-1:0]  hdr_count;

  assign rx_ready   = !reset && (state_q inside {ST_HDR0, ST_HDR1, ST_DATA, ST_CSUM});
  assign fire       = bus.rx_valid && rx_ready;
  assign byte_valid = fire && (state_q == ST_DATA);
  assign hdr_count  = {bus.rx_data, count_q[7:0]};

  boot_loader_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (bus.rx_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wcnt_d       = wcnt_q;
    // Preloaded outside HOLD so every entry path starts a full interval.
    hold_d       = HOLD_W'(RESET_HOLD - 1);
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
`ifdef BOOT_LOADER_CSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      ST_HDR0: if (fire) begin
        count_d = {{(COUNT_WIDTH-8){1'b0}}, bus.rx_data};
        state_d = ST_HDR1;
      end
      ST_HDR1: if (fire) begin
        count_d = hdr_count;
        wcnt_d  = '0;
        if ({1'b0, hdr_count} > CAPACITY) state_d = ST_ERROR;
        else if (hdr_count == '0)         state_d = POST_DATA;
        else                              state_d = ST_DATA;
      end
      ST_DATA: if (fire) begin
`ifdef BOOT_LOADER_CSUM_EN
        csum_d = csum_q ^ bus.rx_data;
`endif
        if (word_valid) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = wcnt_q[ADDR_WIDTH-1:0];
          imem_wdata_d = word_data;
          wcnt_d       = wcnt_q + COUNT_WIDTH'(1);
          if (wcnt_q == count_q - COUNT_WIDTH'(1)) state_d = POST_DATA;
        end
      end
`ifdef BOOT_LOADER_CSUM_EN
      ST_CSUM: if (fire) begin
        state_d = (bus.rx_data == csum_q) ? ST_HOLD : ST_ERROR;
      end
`endif
      ST_HOLD: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q == '0) state_d = ST_RUN;
      end
      ST_RUN, ST_ERROR: ;
      default: state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HDR0;
      count_q      <= '0;
      wcnt_q       <= '0;
      hold_q       <= HOLD_W'(RESET_HOLD - 1);
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
`ifdef BOOT_LOADER_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wcnt_q       <= wcnt_d;
      hold_q       <= hold_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
`ifdef BOOT_LOADER_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.core_reset = (state_q != ST_RUN);
  assign bus.load_done  = (state_q == ST_RUN);
  assign bus.error      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - randomized self-checking bench for boot_loader
// Follows BOOT_LOADER_CSUM_EN: frames carry a checksum byte only when it is defined.
module tb_boot_loader;

  localparam int AW  = 8;
  localparam int R   = 8;
  localparam int CAP = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

  boot_loader #(.ADDR_WIDTH(AW), .RESET_HOLD(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rel_cyc = -1;
  int          err_cyc = -1;
  logic [39:0] wr_q[$];
  logic [7:0]  frame[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write log plus first cycle of core release / error, relative to posedge count.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (bus.imem_we) wr_q.push_back({bus.imem_addr, bus.imem_wdata});
      if (!bus.core_reset && rel_cyc < 0) rel_cyc = cyc;
      if (bus.error && err_cyc < 0) err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_imem_we", bus.imem_we, 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_imem_wdata", bus.imem_wdata, 0);
    check("rst_core_reset", bus.core_reset, 1);
    check("rst_load_done", bus.load_done, 0);
    check("rst_error", bus.error, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_q.delete();
    rel_cyc = -1;
    err_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int pct, output int p, output bit ok);
    logic rdy;
    ok = 1'b0;
    p = -1;
    for (int k = 0; k < 400 && !ok; k++) begin
      bus.rx_valid = ($urandom_range(99) < pct);
      bus.rx_data = bus.rx_valid ? b : 8'($urandom);
      @(negedge clk);
      rdy = bus.rx_ready;
      @(posedge clk);
      #1;
      if (bus.rx_valid && rdy) begin
        ok = 1'b1;
        p = cyc;
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input int first, input int last, input int pct, output int last_p);
    bit ok;
    last_p = -1;
    for (int i = first; i <= last; i++) begin
      send_byte(frame[i], pct, last_p, ok);
      if (!ok) begin
        check("rx_timeout", 0, 1);
        return;
      end
    end
  endtask

  // Reference: decode the frame from its byte rules and predict writes and final state.
  task automatic expect_result(input string name, input int last_p);
    int          n;
    int          nw;
    bit          exp_err;
    logic [31:0] w;
`ifdef BOOT_LOADER_CSUM_EN
    logic [7:0]  x;
`endif
    n = int'({frame[1], frame[0]});
    exp_err = (n > CAP);
    nw = exp_err ? 0 : n;
`ifdef BOOT_LOADER_CSUM_EN
    x = 8'h00;
    for (int i = 0; i < 4 * nw; i++) x ^= frame[2 + i];
    if (!exp_err && frame[2 + 4 * nw] != x) exp_err = 1'b1;
`endif
    repeat (R + 3) @(posedge clk);
    @(negedge clk);
    check({name, "_wr_count"}, wr_q.size(), nw);
    for (int i = 0; i < nw && i < wr_q.size(); i++) begin
      w = {frame[2+4*i+3], frame[2+4*i+2], frame[2+4*i+1], frame[2+4*i]};
      check($sformatf("%s_addr%0d", name, i), wr_q[i][39:32], i);
      check($sformatf("%s_data%0d", name, i), wr_q[i][31:0], w);
    end
    if (exp_err) begin
      check({name, "_err_cycle"}, err_cyc, last_p);
      check({name, "_release"}, rel_cyc, -1);
    end else begin
      check({name, "_release"}, rel_cyc, last_p + R);
      check({name, "_err_cycle"}, err_cyc, -1);
    end
    check({name, "_error"}, bus.error, exp_err);
    check({name, "_load_done"}, bus.load_done, !exp_err);
    check({name, "_core_reset"}, bus.core_reset, exp_err);
    check({name, "_rx_ready"}, bus.rx_ready, 0);
  endtask

  task automatic run_frame(input string name, input int pct);
    int last_p;
    do_reset();
    send_bytes(0, frame.size() - 1, pct, last_p);
    expect_result(name, last_p);
  endtask

  task automatic build_random(input int n, input bit bad);
    logic [7:0] b;
    logic [7:0] x;
    frame.delete();
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
      x ^= b;
    end
`ifdef BOOT_LOADER_CSUM_EN
    frame.push_back(bad ? (x ^ 8'(1 << $urandom_range(7))) : x);
`else
    if (bad) frame.push_back(x);
    if (bad) frame.pop_back();
`endif
  endtask

  task automatic plan_frame(input logic [7:0] csum);
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00, 8'h93, 8'h05, 8'h40, 8'h00};
`ifdef BOOT_LOADER_CSUM_EN
    frame.push_back(csum);
`else
    if (csum == 8'hff) frame.push_back(csum);
`endif
  endtask

  initial begin
    int last_p;
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;

    plan_frame(8'h60);
    run_frame("plan", 100);

`ifdef BOOT_LOADER_CSUM_EN
    plan_frame(8'h61);
    run_frame("badcsum", 100);
`endif

    frame = '{8'h01, 8'h01};
    run_frame("oversize", 100);

    frame = '{8'h00, 8'h00};
`ifdef BOOT_LOADER_CSUM_EN
    frame.push_back(8'h00);
`endif
    run_frame("zero", 100);

    plan_frame(8'h60);
    run_frame("stall", 50);

    plan_frame(8'h60);
    do_reset();
    send_bytes(0, 6, 100, last_p);
    @(negedge clk);
    check("mid_core_reset", bus.core_reset, 1);
    check("mid_wr_count", wr_q.size(), 1);
    run_frame("reload", 100);

    build_random(CAP, 1'b0);
    run_frame("full", 100);

    for (int t = 0; t < 6; t++) begin
      build_random($urandom_range(1, 8), $urandom_range(3) == 0);
      run_frame($sformatf("rand%0d", t), $urandom_range(30, 100));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-stream boot loader that sits directly upstream of the single-cycle core top. It receives a framed program image over a valid/ready byte interface and writes it word-by-word into instruction memory. It holds the core in reset throughout the load, then releases it after a fixed settle interval, replacing file-based memory preload and testbench reset sequencing.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity 2**ADDR_WIDTH words
- RESET_HOLD, 8, cycles core_reset stays high after the last write (>=1)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- rx_valid  input  1  byte available
- rx_data  input  8  byte payload
- rx_ready  output  1  loader accepts byte; transfer occurs when rx_valid && rx_ready at posedge
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  ADDR_WIDTH  word address
- imem_wdata  output  32  word data
- core_reset  output  1  reset to core, active-high
- load_done  output  1  image loaded, core running
- error  output  1  framing/checksum fault, sticky until reset

## Operation
- Frame: COUNT_LO, COUNT_HI (16-bit word count N, little-endian), then N words as 4 bytes each (little-endian), then one checksum byte (XOR of all word bytes; header excluded).
- States: HDR0 -> HDR1 -> DATA -> CSUM -> HOLD -> RUN; ERROR from HDR1 or CSUM.
- HDR0/HDR1 latch count bytes. After HDR1: if N > 2**ADDR_WIDTH -> ERROR; if N == 0 -> CSUM; else DATA.
- DATA: byte counter 0..3 packs bytes; on 4th byte, the word is written at the current address, then the address increments. After word N -> CSUM.
- CSUM: accepted byte compared to running XOR; match -> HOLD, mismatch -> ERROR.
- HOLD: down-counter from RESET_HOLD; at zero -> RUN.
- RUN: core_reset=0, load_done=1. Absorbing until reset.
- ERROR: error=1, core_reset=1. Absorbing until reset.
- rx_ready=1 only in HDR0, HDR1, DATA and CSUM. It is 0 in HOLD, RUN and ERROR, and 0 while reset is high.
- Words beyond address 2**ADDR_WIDTH-1 are never written; the N check guarantees this.

## Timing
- Reset values: rx_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, core_reset 1, load_done 0, error 0. State returns to HDR0; counters and the XOR accumulator clear.
- Reset mid-load: the next cycle is HDR0 with core_reset=1. Already-written memory is not cleared.
- imem_we, imem_addr and imem_wdata are registered. They are valid the cycle after the 4th byte's handshake and are held for exactly one cycle. imem_addr shows the address of that write.
- rx_valid low stalls any receive state indefinitely without side effects.
- Last-byte handshake (or CSUM match) at cycle T: HOLD is entered at T+1; core_reset falls and load_done rises at T+1+RESET_HOLD.
- error rises the cycle after the faulting handshake.

## Configuration
- BOOT_LOADER_CSUM_EN defined: checksum byte is expected and checked as above.
- Not defined: there is no CSUM state and no XOR accumulator. After word N (or when N == 0), go directly to HOLD. ERROR is reachable only on oversize count.

## Structure
- boot_loader_pkg: state enum, BYTES_PER_WORD=4, HDR_BYTES=2, WORD_WIDTH=32.
- Sub-module word_packer: 4-byte little-endian shift/assemble with byte index and word_valid pulse. The top FSM owns addressing, counting and the reset hold.

## Test plan
- N=2, bytes 02 00 13 05 a0 00 93 05 40 00 60 -> writes 0x00a00513 at addr 0, then 0x00400593 at addr 1; core_reset falls 8 cycles after the CSUM byte; load_done=1, error=0.
- Same frame with checksum 0x61 -> no further writes after the 2 words; error=1, core_reset stays 1, rx_ready=0.
- Header 01 01 (N=257, ADDR_WIDTH=8) -> error=1 the cycle after the 2nd byte; no imem_we ever asserted.
- N=0, header 00 00 then checksum 00 -> no writes; HOLD, then RUN after 8 cycles.
- rx_valid toggled randomly during the first frame -> identical writes and final state; no byte lost or duplicated.
- reset pulsed after 5 data bytes, then the full first frame resent -> both words rewritten from addr 0; core_reset=1 throughout until the new HOLD expires.
